// File: rtl/encrypt_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// encrypt_pipe_ctrl
//
// Session controller that sits in front of an encrypt pipeline. The host loads
// a key/configuration set, streams bytes through a valid/ready handshake, and
// then stops the session. The controller drains the pipeline for PIPE_DEPTH
// cycles before returning to idle.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous, active-low reset
//   cfg_load             latch configuration and start a session (IDLE only)
//   cfg_k1/k2/k3 [7:0]   session keys
//   cfg_rot_freq [2:0]   bytes per rotation step, 0 = never rotate
//   cfg_shift_en         shift cipher enable
//   cfg_mode             1 = encrypt/active
//   cfg_stop             end session and drain (RUN only)
//   in_valid, in_data    host byte stream
//   in_ready             host byte accepted when in_valid && in_ready
//   en, din              registered byte strobe and data to the pipeline
//   k1/k2/k3, rot_freq,
//   shift_en, mode       registered session configuration
//   shift_amt            registered rotation step, aligned with en
//   busy                 high in CFG, RUN or DRAIN
//   done                 one-cycle pulse on the first IDLE cycle after drain
//   dbg_state [1:0]      current FSM state (0 IDLE, 1 CFG, 2 RUN, 3 DRAIN)
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on the state (high in RUN), never on
// in_valid, so the host may hold in_valid high for any number of cycles and
// the byte is taken on the first RUN cycle.
// -----------------------------------------------------------------------------
module encrypt_pipe_ctrl #(
    parameter int PIPE_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_load,
    input  logic [7:0] cfg_k1,
    input  logic [7:0] cfg_k2,
    input  logic [7:0] cfg_k3,
    input  logic [2:0] cfg_rot_freq,
    input  logic       cfg_shift_en,
    input  logic       cfg_mode,
    input  logic       cfg_stop,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       en,
    output logic [7:0] din,
    output logic [7:0] k1,
    output logic [7:0] k2,
    output logic [7:0] k3,
    output logic [2:0] rot_freq,
    output logic       shift_en,
    output logic       shift_amt,
    output logic       mode,
    output logic       busy,
    output logic       done,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CFG   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // A depth of 0 would make DRAIN unreachable-to-exit; clamp to one cycle.
    localparam int DRAIN_LOAD = (PIPE_DEPTH < 1) ? 1 : PIPE_DEPTH;
    localparam int CNT_W      = $clog2(DRAIN_LOAD + 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_LOAD);
    localparam logic [CNT_W-1:0] DRAIN_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [2:0]       rot_cnt_q, rot_cnt_d;

    logic       en_q;
    logic [7:0] din_q;
    logic [7:0] k1_q, k2_q, k3_q;
    logic [2:0] rot_freq_q;
    logic       shift_en_q;
    logic       shift_amt_q;
    logic       mode_q;
    logic       done_q;

    logic accept;
    logic load_accept;
    logic stop_accept;
    logic drain_last;
    logic rot_hit;

    assign accept      = in_valid && (state_q == S_RUN);
    assign load_accept = cfg_load && (state_q == S_IDLE);
    assign stop_accept = cfg_stop && (state_q == S_RUN);
    // Counter holds 1 in the final DRAIN cycle; it reaches 0 on the exit edge.
    assign drain_last  = (state_q == S_DRAIN) && (drain_cnt_q <= DRAIN_ONE);
    // Rotation step fires on the byte that completes a rot_freq-sized group.
    assign rot_hit     = accept && (rot_freq_q != 3'd0) &&
                         (({1'b0, rot_cnt_q} + 4'd1) == {1'b0, rot_freq_q});

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A simultaneous cfg_stop is simply not looked at here.
                if (cfg_load) begin
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cfg_stop) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: state decodes
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_RUN);
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
    end

    // ---------------------------------------------------------------------
    // Counters
    // ---------------------------------------------------------------------
    always_comb begin
        drain_cnt_d = drain_cnt_q;
        if (stop_accept) begin
            drain_cnt_d = DRAIN_INIT;
        end else if ((state_q == S_DRAIN) && (drain_cnt_q != '0)) begin
            drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        end
    end

    always_comb begin
        rot_cnt_d = rot_cnt_q;
        if (load_accept) begin
            // Every session starts at rotation phase 0.
            rot_cnt_d = 3'd0;
        end else if (accept && (rot_freq_q != 3'd0)) begin
            rot_cnt_d = rot_hit ? 3'd0 : rot_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt_q <= '0;
            rot_cnt_q   <= 3'd0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
            rot_cnt_q   <= rot_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Registered pipeline-facing outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q        <= 1'b0;
            din_q       <= 8'd0;
            shift_amt_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            en_q        <= accept;
            shift_amt_q <= rot_hit;
            done_q      <= drain_last;
            if (accept) begin
                din_q <= in_data;
            end
        end
    end

    // Configuration only changes on a load accepted in IDLE, so it stays
    // stable for the whole CFG/RUN/DRAIN session.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k1_q       <= 8'd0;
            k2_q       <= 8'd0;
            k3_q       <= 8'd0;
            rot_freq_q <= 3'd0;
            shift_en_q <= 1'b0;
            mode_q     <= 1'b0;
        end else if (load_accept) begin
            k1_q       <= cfg_k1;
            k2_q       <= cfg_k2;
            k3_q       <= cfg_k3;
            rot_freq_q <= cfg_rot_freq;
            shift_en_q <= cfg_shift_en;
            mode_q     <= cfg_mode;
        end
    end

    assign en        = en_q;
    assign din       = din_q;
    assign k1        = k1_q;
    assign k2        = k2_q;
    assign k3        = k3_q;
    assign rot_freq  = rot_freq_q;
    assign shift_en  = shift_en_q;
    assign shift_amt = shift_amt_q;
    assign mode      = mode_q;
    assign done      = done_q;

endmodule
